// File: rtl/sap2_mem_pkg.sv
// Shared constants and types for the SAP-II memory access controller.
//   SAP_ADDR_W / SAP_DATA_W : default memory address / data widths
//   ROM_END                 : first writable address (ROM is 0000H-07FFH)
//   CE_READ / CE_WRITE      : memory CE encodings
//   HIGH_Z                  : released data-bus value
//   PORT_CPU / PORT_IO      : requester port IDs
package sap2_mem_pkg;

    localparam int unsigned SAP_ADDR_W = 16;
    localparam int unsigned SAP_DATA_W = 8;

    localparam logic [SAP_ADDR_W-1:0] ROM_END = 16'h0800;

    localparam logic CE_READ  = 1'b0;
    localparam logic CE_WRITE = 1'b1;

    localparam logic [SAP_DATA_W-1:0] HIGH_Z = {SAP_DATA_W{1'bz}};

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
//   clk_i, clr_i  : clock, synchronous active-high reset
//   req_i[1:0]    : port requests (bit 0 = CPU, bit 1 = I/O)
//   en_i          : allow a grant this cycle
//   upd_i         : load the pointer with upd_port_i (the port just served)
//   upd_port_i    : port ID that completed
//   gnt_o_c[1:0]  : one-hot grant, combinational
module rr_arbiter_2
    import sap2_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       upd_i,
    input  logic       upd_port_i,
    output logic [1:0] gnt_o_c
);

    logic last_q;
    logic last_d;

    // On contention the port not served last wins.
    always_comb begin
        gnt_o_c = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o_c = 2'b01;
                2'b10:   gnt_o_c = 2'b10;
                2'b11:   gnt_o_c = (last_q == PORT_CPU) ? 2'b10 : 2'b01;
                default: gnt_o_c = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = upd_port_i;
        end
    end

    // Reset to "I/O served last" so the first contention goes to the CPU.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            last_q <= PORT_IO;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port access controller for the SAP-II 64K memory (ROM below ROM_END).
// Shares one address/CE/data interface between the CPU (port 0) and the
// monitor/loader path (port 1); every access runs IDLE -> ACCESS -> RESP.
//   CLK, CLR                       : clock, synchronous active-high reset
//   REQn, WEn, ADDRn, WDATAn       : port n request, held until ACKn
//   ACKn, RDATAn, ERRn             : port n completion pulse, read data,
//                                    ROM-write rejection flag
//   MEM_ADDR, MEM_CE, MEM_DATA     : memory address, CE (1 = write),
//                                    bidirectional data bus
module mem_arbiter
    import sap2_mem_pkg::*;
#(
    parameter int unsigned          ADDR_W  = SAP_ADDR_W,
    parameter int unsigned          DATA_W  = SAP_DATA_W,
    parameter logic [ADDR_W-1:0]    ROM_END = ADDR_W'(sap2_mem_pkg::ROM_END)
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    output logic              ACK0,
    output logic [DATA_W-1:0] RDATA0,
    output logic              ERR0,
    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA1,
    output logic              ERR1,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_CE,
    inout  wire  [DATA_W-1:0] MEM_DATA
);

    state_e              state_q, state_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                rej_q, rej_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_ce_q, mem_ce_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [1:0]          gnt;
    logic                arb_en;
    logic                arb_upd;
    logic                sel_port;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter_2 u_arb (
        .clk_i      (CLK),
        .clr_i      (CLR),
        .req_i      ({REQ1, REQ0}),
        .en_i       (arb_en),
        .upd_i      (arb_upd),
        .upd_port_i (port_q),
        .gnt_o_c    (gnt)
    );

    // Winner's request fields.
    always_comb begin
        sel_port  = gnt[1] ? PORT_IO : PORT_CPU;
        sel_we    = gnt[1] ? WE1    : WE0;
        sel_addr  = gnt[1] ? ADDR1  : ADDR0;
        sel_wdata = gnt[1] ? WDATA1 : WDATA0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        rej_d      = rej_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        mem_ce_d   = mem_ce_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        arb_en     = 1'b0;
        arb_upd    = 1'b0;

        case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (|gnt) begin
                    port_d     = sel_port;
                    we_d       = sel_we;
                    wdata_d    = sel_wdata;
                    mem_addr_d = sel_addr;
                    rej_d      = sel_we && (sel_addr < ROM_END);
                    mem_ce_d   = (sel_we && (sel_addr >= ROM_END)) ? CE_WRITE : CE_READ;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // Memory commits / read data is captured at the edge ending ACCESS.
                mem_ce_d = CE_READ;
                if (port_q == PORT_IO) begin
                    ack1_d = 1'b1;
                    err1_d = rej_q;
                    if (!we_q) begin
                        rdata1_d = MEM_DATA;
                    end
                end else begin
                    ack0_d = 1'b1;
                    err0_d = rej_q;
                    if (!we_q) begin
                        rdata0_d = MEM_DATA;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                arb_upd = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= IDLE;
            port_q     <= PORT_CPU;
            we_q       <= 1'b0;
            rej_q      <= 1'b0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            mem_ce_q   <= CE_READ;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            rej_q      <= rej_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            mem_ce_q   <= mem_ce_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Bus is driven only while a write strobe is registered high.
    assign MEM_DATA = mem_ce_q ? wdata_q : {DATA_W{HIGH_Z[0]}};

    assign MEM_ADDR = mem_addr_q;
    assign MEM_CE   = mem_ce_q;
    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign ERR0     = err0_q;
    assign ERR1     = err1_q;
    assign RDATA0   = rdata0_q;
    assign RDATA1   = rdata1_q;

endmodule
